poly_pipe_ctrl: RTL and testbench
=================================

POLY_PIPE_CTRL -- requirements
Module: poly_pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of performance counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream sample x present.
REQ-005 SHALL have port in_ready, output, 1: controller accepts x this cycle.
REQ-006 SHALL have port out_valid, output, 1: datapath output y valid.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts y.
REQ-008 SHALL have port flush, input, 1: discard all in-flight samples.
REQ-009 SHALL have ports load0, load1, load2, output, 1 each: enables for datapath stage 0/1/2 registers.
REQ-010 SHALL have port busy, output, 1: any stage holds a valid sample.
REQ-011 SHALL have ports sample_count, stall_count, output, CNT_WIDTH each: performance counters.

Function
REQ-012 SHALL track one valid bit per stage (v0, v1, v2); out_valid = v2; busy = v0|v1|v2.
REQ-013 SHALL compute en2 = v1 & (!v2 | out_ready); en1 = v0 & (!v1 | en2); en0 = in_valid & in_ready; in_ready = !v0 | en1.
REQ-014 SHALL drive load0 = en0, load1 = en1, load2 = en2, all combinational.
REQ-015 SHALL update v2 <= en2 | (v2 & !out_ready); v1 <= en1 | (v1 & !en2); v0 <= en0 | (v0 & !en1).
REQ-016 SHALL give latency 3: sample accepted at edge T has out_valid high in the cycle after edge T+2.
REQ-017 SHALL sustain one sample per cycle when out_ready is held high.
REQ-018 SHALL hold all loads low and all valid bits unchanged in stages blocked by out_ready low; no sample is lost or duplicated.
REQ-019 SHALL, with flush high, force in_ready, load0, load1, and load2 to 0 and clear v0..v2 at the next edge; flush overrides in_valid and out_ready.
REQ-020 SHALL not count a transfer as completed while flush is high, even if out_valid & out_ready.
REQ-021 SHALL allow simultaneous output handshake and input acceptance in the same cycle with a full pipeline.

Reset
REQ-022 SHALL, with rst high at a clock edge, clear v0..v2 and both counters; rst has priority over flush.
REQ-023 SHALL have, after reset, out_valid=0, busy=0, in_ready=1, load0=in_valid, load1=0, load2=0, and counters=0.
REQ-024 SHALL drop in-flight samples on reset mid-operation, with no out_valid on the following cycle.

Configuration
REQ-025 SHALL, when macro POLY_PIPE_CTRL_PERF_EN is defined, increment sample_count on each out_valid&out_ready&!flush and increment stall_count on each cycle with out_valid&!out_ready.
REQ-026 SHALL saturate both counters at 2^CNT_WIDTH-1, with no wrap-around.
REQ-027 SHALL, when POLY_PIPE_CTRL_PERF_EN is undefined, keep both count ports present and tie them to 0 with no counter flops.

Structure
REQ-028 SHALL place stage-count constant (3) and the counter saturation helper in shared package poly_pipe_pkg.
REQ-029 SHALL implement the saturating counter as one sub-module, sat_counter, instantiated twice.
REQ-030 SHALL be paired with the existing polynomial datapath by a top wrapper outside this block's scope.

Verification
REQ-031 SHALL cover streaming: in_valid=1 and out_ready=1 for 10 cycles -> first out_valid at cycle 3 followed by 10 consecutive out_valid cycles; with x=1 and coefficients (2,4,6), y=12.
REQ-032 SHALL cover backpressure: fill 3 samples, then out_ready=0 for 5 cycles -> in_ready=0 after pipeline full, all loads 0, and stall_count=5 (PERF_EN).
REQ-033 SHALL cover flush: 3 samples in flight, flush pulsed 1 cycle -> busy=0 and out_valid=0 on the next cycle, with sample_count unchanged.
REQ-034 SHALL cover reset mid-run: rst asserted with v0..v2=1 -> on the next cycle out_valid=0, in_ready=1, and counters=0.
REQ-035 SHALL cover saturation: CNT_WIDTH=4 with 20 output handshakes -> sample_count=15.
REQ-036 SHALL cover no-PERF build: identical handshake trace to the PERF build, with sample_count=0 and stall_count=0 throughout.

Source files
------------

// File: rtl/poly_pipe_pkg.sv
// Shared constants and the saturating-increment helper used by poly_pipe_ctrl.
package poly_pipe_pkg;

    localparam int NUM_STAGES = 3;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

    // Counters narrower than 32 bits are zero-extended by the caller.
    function automatic logic sat_can_inc(input logic [31:0] value, input logic [31:0] max_value);
        return value != max_value;
    endfunction

endpackage

// File: rtl/poly_pipe_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping. Synchronous active-high reset.
module sat_counter
    import poly_pipe_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] r_count;
    logic             w_step;

    assign w_step = i_inc && sat_can_inc(32'(r_count), 32'(MAX_COUNT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/poly_pipe_ctrl.sv
// Valid/ready controller for the 3-stage polynomial datapath.
// Performance counters are built only when POLY_PIPE_CTRL_PERF_EN is defined; otherwise they read 0.
module poly_pipe_ctrl
    import poly_pipe_pkg::*;
#(
    parameter int CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 load0,
    output logic                 load1,
    output logic                 load2,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    stage_vec_t r_valid;
    logic       w_en0;
    logic       w_en1;
    logic       w_en2;
    logic       w_in_ready;

    // Enables ripple back from the output so a full pipe can advance every stage at once.
    always_comb begin
        w_en2      = 1'b0;
        w_en1      = 1'b0;
        w_en0      = 1'b0;
        w_in_ready = 1'b0;
        if (!flush) begin
            w_en2      = r_valid[2] && (!r_valid[2] || out_ready) ? r_valid[1] : 1'b0;
            w_en2      = r_valid[1] && (!r_valid[2] || out_ready);
            w_en1      = r_valid[0] && (!r_valid[1] || w_en2);
            w_in_ready = !r_valid[0] || w_en1;
            w_en0      = in_valid && w_in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
        end else begin
            r_valid[2] <= w_en2 || (r_valid[2] && !out_ready);
            r_valid[1] <= w_en1 || (r_valid[1] && !w_en2);
            r_valid[0] <= w_en0 || (r_valid[0] && !w_en1);
        end
    end

    assign in_ready  = w_in_ready;
    assign load0     = w_en0;
    assign load1     = w_en1;
    assign load2     = w_en2;
    assign out_valid = r_valid[2];
    assign busy      = |r_valid;

`ifdef POLY_PIPE_CTRL_PERF_EN
    logic w_sample_inc;
    logic w_stall_inc;

    // A handshake during flush is discarded, so it is not counted as a completed sample.
    assign w_sample_inc = r_valid[2] && out_ready && !flush;
    assign w_stall_inc  = r_valid[2] && !out_ready;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_sample_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_sample_inc),
        .o_count(sample_count)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_stall_inc),
        .o_count(stall_count)
    );
`else
    assign sample_count = '0;
    assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_poly_pipe_ctrl.sv
// Self-checking bench for poly_pipe_ctrl: directed vector table, corner-case sequences and a
// randomized run against a slot/queue reference model with a shadow polynomial datapath.
module tb_poly_pipe_ctrl;

`ifdef POLY_PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [3:0]  curX;
    logic        in_ready, out_valid, load0, load1, load2, busy;
    logic [15:0] sample_count, stall_count;
    logic        in_ready4, out_valid4, load04, load14, load24, busy4;
    logic [3:0]  sample_count4, stall_count4;

    poly_pipe_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .load0(load0), .load1(load1), .load2(load2), .busy(busy),
        .sample_count(sample_count), .stall_count(stall_count)
    );

    poly_pipe_ctrl #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready), .flush(flush),
        .load0(load04), .load1(load14), .load2(load24), .busy(busy4),
        .sample_count(sample_count4), .stall_count(stall_count4)
    );

    // Shadow datapath computing y = 6x^2 + 4x + 2 (coefficients 2,4,6) by Horner, driven by the DUT loads.
    int unsigned sd0 = 0, sd1Acc = 0, sd1X = 0, sd2 = 0;
    always @(posedge clk) begin
        if (load0) sd0 <= curX;
        if (load1) begin
            sd1Acc <= 6 * sd0 + 4;
            sd1X   <= sd0;
        end
        if (load2) sd2 <= sd1Acc * sd1X + 2;
    end

    function automatic int unsigned expY(input int unsigned x);
        return 6 * x * x + 4 * x + 2;
    endfunction

    int checks = 0;
    int failures = 0;

    // Reference model: three slots, a FIFO of accepted x values, and unbounded handshake tallies.
    bit          mOcc[4];
    int unsigned mq[$];
    longint      mSample = 0, mStall = 0;

    typedef struct {
        bit inReady, outValid, busy, load0, load1, load2, fire;
    } pred_t;

    bit          sInReady, sOutValid, sLoad0, sLoad1, sLoad2, sBusy;
    int unsigned sY;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit f, input bit iv, input bit ordy, input logic [3:0] x);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        curX      = x;
    endtask

    function automatic longint satTo(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // A sample leaves its slot when the slot ahead will be free after this cycle's moves.
    function automatic pred_t predict();
        pred_t p;
        bit    leaves[3];
        bit    freeAfter[4];
        freeAfter[3] = out_ready;
        for (int k = 2; k >= 0; k--) begin
            leaves[k]    = !flush && mOcc[k] && freeAfter[k+1];
            freeAfter[k] = !mOcc[k] || leaves[k];
        end
        p.outValid = mOcc[2];
        p.busy     = mOcc[0] || mOcc[1] || mOcc[2];
        p.inReady  = !flush && freeAfter[0];
        p.load0    = in_valid && p.inReady;
        p.load1    = leaves[0];
        p.load2    = leaves[1];
        p.fire     = leaves[2];
        return p;
    endfunction

    function automatic void updateModel(input pred_t p);
        if (rst) begin
            for (int k = 0; k < 4; k++) mOcc[k] = 1'b0;
            mq.delete();
            mSample = 0;
            mStall  = 0;
        end else begin
            if (mOcc[2] && !out_ready) mStall++;
            if (flush) begin
                for (int k = 0; k < 4; k++) mOcc[k] = 1'b0;
                mq.delete();
            end else begin
                if (p.fire) begin
                    mSample++;
                    void'(mq.pop_front());
                end
                if (p.load0) mq.push_back(int'(curX));
                mOcc[2] = (mOcc[2] && !p.fire)  || p.load2;
                mOcc[1] = (mOcc[1] && !p.load2) || p.load1;
                mOcc[0] = (mOcc[0] && !p.load1) || p.load0;
            end
        end
    endfunction

    task automatic step(input bit doCheck);
        pred_t p;
        @(negedge clk);
        p         = predict();
        sInReady  = in_ready;
        sOutValid = out_valid;
        sLoad0    = load0;
        sLoad1    = load1;
        sLoad2    = load2;
        sBusy     = busy;
        sY        = sd2;
        if (doCheck) begin
            checkOutput("inReady",  in_ready,  p.inReady);
            checkOutput("outValid", out_valid, p.outValid);
            checkOutput("busy",     busy,      p.busy);
            checkOutput("load0",    load0,     p.load0);
            checkOutput("load1",    load1,     p.load1);
            checkOutput("load2",    load2,     p.load2);
            checkOutput("sampleCount", sample_count, PERF ? satTo(mSample, 16) : 0);
            checkOutput("stallCount",  stall_count,  PERF ? satTo(mStall, 16) : 0);
            checkOutput("sampleCount4", sample_count4, PERF ? satTo(mSample, 4) : 0);
            checkOutput("stallCount4",  stall_count4,  PERF ? satTo(mStall, 4) : 0);
            checkOutput("handshake4", {in_ready4, out_valid4, busy4, load04, load14, load24},
                        {p.inReady, p.outValid, p.busy, p.load0, p.load1, p.load2});
            if (p.fire && !rst) begin
                if (mq.size() == 0) checkOutput("scoreboardDepth", 0, 1);
                else                checkOutput("dataY", sd2, expY(mq[0]));
            end
        end
        @(posedge clk);
        updateModel(p);
        #1;
    endtask

    typedef struct {
        bit r, f, iv, ordy;
        bit expIr, expOv, expBusy, expL0, expL1, expL2;
    } vec_t;

    vec_t tbl[12];
    int   firstOv, runLen, badY;
    longint savedCount;

    initial begin
        tbl[0]  = '{0,0,1,1, 1,0,0, 1,0,0};
        tbl[1]  = '{0,0,1,1, 1,0,1, 1,1,0};
        tbl[2]  = '{0,0,1,1, 1,0,1, 1,1,1};
        tbl[3]  = '{0,0,1,1, 1,1,1, 1,1,1};
        tbl[4]  = '{0,0,0,0, 0,1,1, 0,0,0};
        tbl[5]  = '{0,0,1,0, 0,1,1, 0,0,0};
        tbl[6]  = '{0,0,0,1, 1,1,1, 0,1,1};
        tbl[7]  = '{0,0,0,0, 1,1,1, 0,0,0};
        tbl[8]  = '{0,1,1,1, 0,1,1, 0,0,0};
        tbl[9]  = '{0,0,0,0, 1,0,0, 0,0,0};
        tbl[10] = '{1,0,1,1, 1,0,0, 1,0,0};
        tbl[11] = '{0,0,0,1, 1,0,0, 0,0,0};

        applyStimulus(1, 0, 0, 1, 0);
        step(0);
        step(1);
        checkOutput("reset_outValid", out_valid, 0);
        checkOutput("reset_inReady", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ordy, 4'(i));
            step(1);
            checkOutput($sformatf("vec%0d_flags", i),
                        {sInReady, sOutValid, sBusy, sLoad0, sLoad1, sLoad2},
                        {tbl[i].expIr, tbl[i].expOv, tbl[i].expBusy, tbl[i].expL0, tbl[i].expL1, tbl[i].expL2});
        end

        // Streaming: 10 samples of x=1 with out_ready held high.
        applyStimulus(1, 0, 0, 1, 0);
        step(1);
        firstOv = -1;
        runLen  = 0;
        badY    = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(0, 0, c < 10, 1, 1);
            step(1);
            if (sOutValid) begin
                if (firstOv < 0) firstOv = c;
                runLen++;
                if (sY != 12) badY++;
            end
        end
        checkOutput("stream_firstOutValid", firstOv, 3);
        checkOutput("stream_runLength", runLen, 10);
        checkOutput("stream_badY", badY, 0);

        // Backpressure: fill three samples, then hold out_ready low for five cycles.
        applyStimulus(1, 0, 0, 0, 0);
        step(1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 1, 0, 4'(c + 3));
            step(1);
        end
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 1, 0, 4'(9));
            step(1);
            checkOutput("bp_inReady", sInReady, 0);
            checkOutput("bp_loads", {sLoad0, sLoad1, sLoad2}, 3'b000);
        end
        checkOutput("bp_stallCount", stall_count, PERF ? 5 : 0);
        checkOutput("bp_stallCount4", stall_count4, PERF ? 5 : 0);

        // Flush with three samples in flight and out_ready high.
        savedCount = longint'(sample_count);
        applyStimulus(0, 1, 1, 1, 0);
        step(1);
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_outValid", out_valid, 0);
        checkOutput("flush_sampleCount", sample_count, savedCount);
        applyStimulus(0, 0, 0, 1, 0);
        step(1);

        // Reset in the middle of a run with the pipeline full.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 1, 1, 4'(c));
            step(1);
        end
        checkOutput("midrun_busyBeforeReset", busy, 1);
        applyStimulus(1, 0, 1, 1, 0);
        step(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("midrun_outValid", out_valid, 0);
        checkOutput("midrun_inReady", in_ready, 1);
        checkOutput("midrun_counters", {sample_count, stall_count}, 32'h0);
        step(1);

        // Saturation: twenty handshakes into the 4-bit counter instance.
        applyStimulus(1, 0, 0, 1, 0);
        step(1);
        for (int c = 0; c < 25; c++) begin
            applyStimulus(0, 0, c < 20, 1, 4'(c));
            step(1);
        end
        checkOutput("sat_sampleCount4", sample_count4, PERF ? 15 : 0);
        checkOutput("sat_sampleCount16", sample_count, PERF ? 20 : 0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                          4'($urandom_range(0, 15)));
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
